// File: rtl/down_timer.sv
// Loadable down-counting interval timer: counts a host-loaded value down to
// zero while enabled, pulses expired at terminal count, then reloads or idles.
module down_timer #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             auto_reload,
    input  logic             enable,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             expired
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             mode_q, mode_d;
    logic             expired_q, expired_d;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q   <= IDLE;
            count_q   <= '0;
            reload_q  <= '0;
            mode_q    <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            reload_q  <= reload_d;
            mode_q    <= mode_d;
            expired_q <= expired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        reload_d  = reload_q;
        mode_d    = mode_q;
        expired_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    // A zero load is accepted but expires on the spot.
                    if (load_data != '0) begin
                        count_d  = load_data;
                        reload_d = load_data;
                        mode_d   = auto_reload;
                        state_d  = RUN;
                    end else begin
                        expired_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    count_d = '0;
                    state_d = IDLE;
                end else if (enable) begin
                    if (count_q == WIDTH'(1)) begin
                        expired_d = 1'b1;
                        if (mode_q) begin
                            count_d = reload_q;
                        end else begin
                            count_d = '0;
                            state_d = IDLE;
                        end
                    end else if (count_q > WIDTH'(1)) begin
                        count_d = count_q - WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    assign load_ready = (state_q == IDLE);
    assign busy       = (state_q == RUN);
    assign count      = count_q;
    assign expired    = expired_q;

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: directed vector table, hand-written
// corner sequences, and randomized traffic against a behavioural model.
module tb_down_timer;

    logic       clk;
    logic       rst_;
    logic       load_valid;
    logic       load_ready;
    logic [4:0] load_data;
    logic       auto_reload;
    logic       enable;
    logic       abort;
    logic [4:0] count;
    logic       busy;
    logic       expired;

    int nvec = 0;
    int nerr = 0;

    down_timer #(.WIDTH(5)) dut (
        .clk        (clk),
        .rst_       (rst_),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .auto_reload(auto_reload),
        .enable     (enable),
        .abort      (abort),
        .count      (count),
        .busy       (busy),
        .expired    (expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: a timer is either idle or running with some number of
    // enabled edges left before it fires.
    bit m_running;
    int m_left;
    int m_period;
    bit m_periodic;
    bit m_fired;

    task automatic model_reset();
        m_running  = 1'b0;
        m_left     = 0;
        m_period   = 0;
        m_periodic = 1'b0;
        m_fired    = 1'b0;
    endtask

    task automatic model_step();
        m_fired = 1'b0;
        if (!m_running) begin
            if (load_valid) begin
                if (int'(load_data) == 0) begin
                    m_fired = 1'b1;
                end else begin
                    m_running  = 1'b1;
                    m_left     = int'(load_data);
                    m_period   = int'(load_data);
                    m_periodic = auto_reload;
                end
            end
        end else if (abort) begin
            m_running = 1'b0;
            m_left    = 0;
        end else if (enable) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_fired = 1'b1;
                if (m_periodic) m_left = m_period;
                else m_running = 1'b0;
            end
        end
    endtask

    task automatic apply(input logic lv, input logic [4:0] ld, input logic ar,
                         input logic en, input logic ab);
        @(negedge clk);
        load_valid  = lv;
        load_data   = ld;
        auto_reload = ar;
        enable      = en;
        abort       = ab;
        @(posedge clk);
        if (!rst_) model_reset();
        else model_step();
        #1;
    endtask

    task automatic check(input string name, input logic [4:0] ec,
                         input logic eb, input logic ee);
        nvec++;
        if (count !== ec || busy !== eb || load_ready !== !eb || expired !== ee) begin
            nerr++;
            $display("FAIL %s: got count=%0d busy=%b ready=%b expired=%b, want count=%0d busy=%b ready=%b expired=%b",
                     name, count, busy, load_ready, expired, ec, eb, !eb, ee);
        end
    endtask

    task automatic check_model(input string name);
        check(name, 5'(m_left), m_running, m_fired);
    endtask

    typedef struct {
        logic       lv;
        logic [4:0] ld;
        logic       ar;
        logic       en;
        logic       ab;
        logic [4:0] cnt;
        logic       bsy;
        logic       exp;
    } vec_t;

    vec_t tbl[$];

    initial begin
        // One-shot load 5 with enable held
        tbl.push_back('{1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0});
        // Periodic load 3
        tbl.push_back('{1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0});
        // Pause, load while busy, abort with enable
        tbl.push_back('{1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0});
        // Zero load expires immediately and stays idle
        tbl.push_back('{1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0});
    end

    initial begin
        rst_        = 1'b0;
        load_valid  = 1'b0;
        load_data   = 5'd0;
        auto_reload = 1'b0;
        enable      = 1'b0;
        abort       = 1'b0;
        model_reset();
        #12;
        check("reset", 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_ = 1'b1;

        foreach (tbl[i]) begin
            apply(tbl[i].lv, tbl[i].ld, tbl[i].ar, tbl[i].en, tbl[i].ab);
            check($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].bsy, tbl[i].exp);
        end

        // Maximum load: 31 enabled edges to expiry
        apply(1'b1, 5'd31, 1'b0, 1'b1, 1'b0);
        check("max_load", 5'd31, 1'b1, 1'b0);
        for (int k = 1; k <= 31; k++) begin
            apply(1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
            check($sformatf("max_step%0d", k), 5'(31 - k), (k != 31), (k == 31));
        end

        // Reset asserted mid-RUN acts at once and never fires
        apply(1'b1, 5'd10, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) apply(1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        check("pre_reset_run", 5'd6, 1'b1, 1'b0);
        @(negedge clk);
        #2 rst_ = 1'b0;
        #1;
        model_reset();
        check("async_reset", 5'd0, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            apply(1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
            check("held_reset", 5'd0, 1'b0, 1'b0);
        end
        @(negedge clk);
        rst_ = 1'b1;
        apply(1'b1, 5'd7, 1'b0, 1'b1, 1'b0);
        check("load_after_reset", 5'd7, 1'b1, 1'b0);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic [4:0] d;
            d = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 4));
            apply($urandom_range(0, 1) == 1, d, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
            check_model($sformatf("rand%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
